dp_op_arbiter: RTL

- Shares the single register-file datapath (op/src1/src2/dest micro-op interface, overflow flag) between two micro-op requesters.
  - Requester 0: the sample-processing sequencer.
  - Requester 1: the coefficient-load / maintenance sequencer.
- Arbitrates round-robin, supports locked multi-op sequences, and issues one registered micro-op per cycle.
- Routes datapath overflow back to whichever requester issued the op.
- Sits between the two sequencers and the datapath, inside the filter top.

---
 rtl/dp_arb_pkg.sv | 17 +
 rtl/dp_arb_lock_timer.sv | 23 ++
 rtl/dp_op_arbiter.sv | 103 ++++++++++
 3 files changed

// File: rtl/dp_arb_pkg.sv
// dp_arb_pkg: shared opcodes, arbiter state encoding and micro-op struct for dp_op_arbiter.
package dp_arb_pkg;
  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_COPY  = 3'd1;
  localparam logic [2:0] OP_LOAD1 = 3'd2;
  localparam logic [2:0] OP_LOAD2 = 3'd3;
  localparam logic [2:0] OP_ADD   = 3'd4;
  localparam logic [2:0] OP_SUB   = 3'd5;
  localparam logic [2:0] OP_MUL   = 3'd6;
  typedef enum logic [1:0] {ARB_FREE, ARB_OWN0, ARB_OWN1} arb_state_e;
  typedef struct packed {
    logic [2:0] op;
    logic [3:0] src1;
    logic [3:0] src2;
    logic [3:0] dest;
  } uop_t;
endpackage

// File: rtl/dp_arb_lock_timer.sv
// dp_arb_lock_timer: counts idle cycles of a locked owner and pulses expire on the LOCK_MAX-th one.
module dp_arb_lock_timer #(
  parameter int LOCK_MAX = 16,
  parameter int CNT_W    = 5
) (
  input  logic clk,
  input  logic n_rst,
  input  logic active,
  input  logic owner_valid,
  input  logic accept,
  output logic expire
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign expire = active & ~owner_valid & (cnt_q == CNT_W'(LOCK_MAX - 1));
  // A valid-but-stalled owner holds the count rather than advancing it.
  always_comb begin
    cnt_d = (!active || accept || expire) ? '0 : owner_valid ? cnt_q : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/dp_op_arbiter.sv
// dp_op_arbiter: round-robin, lockable arbiter sharing the datapath micro-op port between two sequencers.
// Define DP_ARB_HAZARD_EN to stall ops that read the register written by the op currently issued.
module dp_op_arbiter
  import dp_arb_pkg::*;
#(
  parameter int LOCK_MAX = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       req0_valid,
  input  logic [2:0] req0_op,
  input  logic [3:0] req0_src1,
  input  logic [3:0] req0_src2,
  input  logic [3:0] req0_dest,
  input  logic       req0_lock,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [2:0] req1_op,
  input  logic [3:0] req1_src1,
  input  logic [3:0] req1_src2,
  input  logic [3:0] req1_dest,
  input  logic       req1_lock,
  output logic       req1_ready,
  output logic [2:0] op,
  output logic [3:0] src1,
  output logic [3:0] src2,
  output logic [3:0] dest,
  input  logic       overflow,
  output logic       ovf0,
  output logic       ovf1,
  output logic       lock_err
);
  arb_state_e state_q, state_d;
  uop_t uop_q, uop_d, r0, r1;
  logic last_q, last_d, tag_q, tag_d;
  logic ovf0_q, ovf0_d, ovf1_q, ovf1_d, lock_err_q, lock_err_d;
  logic haz0, haz1, e0, e1, acc, gsel, lock_sel, active, owner_valid, expire;

  assign r0 = {req0_op, req0_src1, req0_src2, req0_dest};
  assign r1 = {req1_op, req1_src1, req1_src2, req1_dest};
  assign active = state_q != ARB_FREE;
  assign owner_valid = (state_q == ARB_OWN1) ? req1_valid : req0_valid;

`ifdef DP_ARB_HAZARD_EN
  assign haz0 = (uop_q.op != OP_NOP) && (req0_src1 == uop_q.dest || req0_src2 == uop_q.dest);
  assign haz1 = (uop_q.op != OP_NOP) && (req1_src1 == uop_q.dest || req1_src2 == uop_q.dest);
`else
  assign haz0 = 1'b0;
  assign haz1 = 1'b0;
`endif

  dp_arb_lock_timer #(.LOCK_MAX(LOCK_MAX), .CNT_W(CNT_W)) u_timer (
    .clk(clk), .n_rst(n_rst), .active(active), .owner_valid(owner_valid),
    .accept(acc), .expire(expire)
  );

  // last_q = 1 means requester 1 was granted most recently, so requester 0 wins a tie.
  always_comb begin
    e0 = req0_valid & ~haz0;
    e1 = req1_valid & ~haz1;
    req0_ready = (state_q == ARB_FREE) ? e0 & (~e1 | last_q) : (state_q == ARB_OWN0) & e0 & ~expire;
    req1_ready = (state_q == ARB_FREE) ? e1 & (~e0 | ~last_q) : (state_q == ARB_OWN1) & e1 & ~expire;
    acc = req0_ready | req1_ready;
    gsel = req1_ready;
    lock_sel = gsel ? req1_lock : req0_lock;
    uop_d = acc ? (gsel ? r1 : r0) : {OP_NOP, uop_q.src1, uop_q.src2, uop_q.dest};
    tag_d = acc ? gsel : tag_q;
    last_d = acc ? gsel : last_q;
    ovf0_d = overflow & (uop_q.op != OP_NOP) & ~tag_q;
    ovf1_d = overflow & (uop_q.op != OP_NOP) & tag_q;
    lock_err_d = lock_err_q | expire;
    state_d = expire ? ARB_FREE : !acc ? state_q : !lock_sel ? ARB_FREE : gsel ? ARB_OWN1 : ARB_OWN0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= ARB_FREE;
      uop_q      <= '0;
      last_q     <= 1'b1;
      tag_q      <= 1'b0;
      ovf0_q     <= 1'b0;
      ovf1_q     <= 1'b0;
      lock_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      uop_q      <= uop_d;
      last_q     <= last_d;
      tag_q      <= tag_d;
      ovf0_q     <= ovf0_d;
      ovf1_q     <= ovf1_d;
      lock_err_q <= lock_err_d;
    end
  end

  assign op       = uop_q.op;
  assign src1     = uop_q.src1;
  assign src2     = uop_q.src2;
  assign dest     = uop_q.dest;
  assign ovf0     = ovf0_q;
  assign ovf1     = ovf1_q;
  assign lock_err = lock_err_q;
endmodule
